// File: rtl/ctrl_flush_stage_reg_if.sv
// ctrl_flush_stage_reg_if: ID->EX control word bus for ctrl_flush_stage_reg.
// The master side (control unit) drives S, stall and ctrl_in; the slave side
// (the stage register) returns the registered control word and window status.
interface ctrl_flush_stage_reg_if #(
  parameter int CW = 20
);
  logic          S;
  logic          stall;
  logic [CW-1:0] ctrl_in;
  logic [CW-1:0] ctrl_out;
  logic          valid_out;
  logic          squash_active;
  logic [3:0]    squash_rem;

  modport master (
    output S, stall, ctrl_in,
    input  ctrl_out, valid_out, squash_active, squash_rem
  );

  modport slave (
    input  S, stall, ctrl_in,
    output ctrl_out, valid_out, squash_active, squash_rem
  );
endinterface

// File: rtl/ctrl_flush_stage_reg.sv
// ctrl_flush_stage_reg: ID->EX control word register with stall, flush
// bubbles and a FLUSH_CYCLES-long bubble window. KEEP_MASK bits pass ctrl_in
// through during bubbles. All outputs are registered.
// Optional macro CTRL_FLUSH_STATS_EN adds saturating flush_count and
// bubble_count outputs.
module ctrl_flush_stage_reg #(
  parameter int            CW           = 20,
  parameter logic [CW-1:0] NOP_WORD     = '0,
  parameter logic [CW-1:0] KEEP_MASK    = '0,
  parameter int            FLUSH_CYCLES = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  ctrl_flush_stage_reg_if.slave bus
`ifdef CTRL_FLUSH_STATS_EN
  ,
  output logic [15:0]           flush_count,
  output logic [15:0]           bubble_count
`endif
);

  localparam int            RW       = $clog2(FLUSH_CYCLES + 1);
  localparam logic [RW-1:0] REM_INIT = RW'(FLUSH_CYCLES - 1);

  logic [CW-1:0] bubble_word;
  logic [CW-1:0] ctrl_q;
  logic          valid_q;
  logic          active_q;
  logic [RW-1:0] rem_q;
  logic [3:0]    rem_ext;

  assign bubble_word = (bus.ctrl_in & KEEP_MASK) | (NOP_WORD & ~KEEP_MASK);

  // Stage register: reset > flush request > stall > window drain > normal load.
  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_q   <= NOP_WORD;
      valid_q  <= 1'b0;
      active_q <= 1'b0;
      rem_q    <= '0;
    end else if (bus.S) begin
      ctrl_q   <= bubble_word;
      valid_q  <= 1'b0;
      active_q <= 1'b1;
      rem_q    <= REM_INIT;
    end else if (bus.stall) begin
      ctrl_q   <= ctrl_q;
      valid_q  <= valid_q;
      active_q <= active_q;
      rem_q    <= rem_q;
    end else if (rem_q != '0) begin
      ctrl_q   <= bubble_word;
      valid_q  <= 1'b0;
      active_q <= 1'b1;
      rem_q    <= rem_q - 1'b1;
    end else begin
      ctrl_q   <= bus.ctrl_in;
      valid_q  <= 1'b1;
      active_q <= 1'b0;
      rem_q    <= '0;
    end
  end

  // Zero-extend the window remainder to the fixed 4-bit port.
  always_comb begin
    rem_ext         = '0;
    rem_ext[RW-1:0] = rem_q;
  end

  assign bus.ctrl_out      = ctrl_q;
  assign bus.valid_out     = valid_q;
  assign bus.squash_active = active_q;
  assign bus.squash_rem    = rem_ext;

`ifdef CTRL_FLUSH_STATS_EN
  logic load_bubble;
  assign load_bubble = bus.S || (!bus.stall && (rem_q != '0));

  // Saturating counters of flush requests and loaded bubbles.
  always_ff @(posedge clk) begin
    if (reset) begin
      flush_count  <= '0;
      bubble_count <= '0;
    end else begin
      if (bus.S && (flush_count != '1))
        flush_count <= flush_count + 16'd1;
      if (load_bubble && (bubble_count != '1))
        bubble_count <= bubble_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ctrl_flush_stage_reg.sv
// tb_ctrl_flush_stage_reg: scoreboard bench for ctrl_flush_stage_reg.
// Three instances: FLUSH_CYCLES=1, FLUSH_CYCLES=3, FLUSH_CYCLES=3 with
// KEEP_MASK=1. Stats checks are compiled when CTRL_FLUSH_STATS_EN is defined.
module tb_ctrl_flush_stage_reg;

  typedef struct packed {
    logic [19:0] c;
    logic        v;
    logic        a;
    logic [3:0]  r;
  } exp_t;

  logic clk = 1'b0;
  logic r1, r3, rk;
  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  exp_t q1[$];
  exp_t q3[$];
  exp_t qk[$];

  always #5 clk = ~clk;

  ctrl_flush_stage_reg_if #(.CW(20)) b1 ();
  ctrl_flush_stage_reg_if #(.CW(20)) b3 ();
  ctrl_flush_stage_reg_if #(.CW(20)) bk ();

`ifdef CTRL_FLUSH_STATS_EN
  logic [15:0] fc1, bc1, fc3, bc3, fck, bck;
`endif

  ctrl_flush_stage_reg #(
    .CW(20), .NOP_WORD(20'h00000), .KEEP_MASK(20'h00000), .FLUSH_CYCLES(1)
  ) u_d1 (
    .clk(clk), .reset(r1), .bus(b1.slave)
`ifdef CTRL_FLUSH_STATS_EN
    , .flush_count(fc1), .bubble_count(bc1)
`endif
  );

  ctrl_flush_stage_reg #(
    .CW(20), .NOP_WORD(20'h00000), .KEEP_MASK(20'h00000), .FLUSH_CYCLES(3)
  ) u_d3 (
    .clk(clk), .reset(r3), .bus(b3.slave)
`ifdef CTRL_FLUSH_STATS_EN
    , .flush_count(fc3), .bubble_count(bc3)
`endif
  );

  ctrl_flush_stage_reg #(
    .CW(20), .NOP_WORD(20'h00000), .KEEP_MASK(20'h00001), .FLUSH_CYCLES(3)
  ) u_dk (
    .clk(clk), .reset(rk), .bus(bk.slave)
`ifdef CTRL_FLUSH_STATS_EN
    , .flush_count(fck), .bubble_count(bck)
`endif
  );

  task automatic check(input string nm, input exp_t e, input exp_t act);
    n_cmp++;
    if (act !== e) begin
      n_err++;
      $display("FAIL %s: got ctrl=%h v=%b act=%b rem=%0d, want ctrl=%h v=%b act=%b rem=%0d",
               nm, act.c, act.v, act.a, act.r, e.c, e.v, e.a, e.r);
    end
  endtask

  task automatic check16(input string nm, input logic [15:0] act, input logic [15:0] want);
    n_cmp++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, want);
    end
  endtask

  // Drive one cycle of stimulus on DUT d and queue the response expected
  // after the following rising edge.
  task automatic step(input int d, input logic rst, input logic s, input logic st,
                      input logic [19:0] ci, input logic [19:0] ec, input logic ev,
                      input logic ea, input logic [3:0] er);
    exp_t e;
    e = '{c: ec, v: ev, a: ea, r: er};
    @(negedge clk);
    case (d)
      1: begin r1 = rst; b1.S = s; b1.stall = st; b1.ctrl_in = ci; q1.push_back(e); end
      3: begin r3 = rst; b3.S = s; b3.stall = st; b3.ctrl_in = ci; q3.push_back(e); end
      default: begin rk = rst; bk.S = s; bk.stall = st; bk.ctrl_in = ci; qk.push_back(e); end
    endcase
  endtask

  // Monitor: after each rising edge, compare every DUT that has a pending expectation.
  always @(posedge clk) begin
    #1;
    if (q1.size() != 0)
      check("d1", q1.pop_front(), {b1.ctrl_out, b1.valid_out, b1.squash_active, b1.squash_rem});
    if (q3.size() != 0)
      check("d3", q3.pop_front(), {b3.ctrl_out, b3.valid_out, b3.squash_active, b3.squash_rem});
    if (qk.size() != 0)
      check("dk", qk.pop_front(), {bk.ctrl_out, bk.valid_out, bk.squash_active, bk.squash_rem});
  end

  initial begin
    r1 = 1'b1; r3 = 1'b1; rk = 1'b1;
    b1.S = 1'b0; b1.stall = 1'b0; b1.ctrl_in = '0;
    b3.S = 1'b0; b3.stall = 1'b0; b3.ctrl_in = '0;
    bk.S = 1'b0; bk.stall = 1'b0; bk.ctrl_in = '0;

    // FLUSH_CYCLES = 1: reset, single flush, S beats stall, plain stall, reset.
    //       d rst S st ctrl_in    exp_ctrl   v  a  rem
    step(1, 1, 0, 0, 20'hFFFFF, 20'h00000, 0, 0, 0);
    step(1, 1, 0, 0, 20'hFFFFF, 20'h00000, 0, 0, 0);
    step(1, 0, 0, 0, 20'hFFFFF, 20'hFFFFF, 1, 0, 0);
    step(1, 0, 0, 0, 20'h12345, 20'h12345, 1, 0, 0);
    step(1, 0, 1, 0, 20'h12345, 20'h00000, 0, 1, 0);
    step(1, 0, 0, 0, 20'h12345, 20'h12345, 1, 0, 0);
    step(1, 0, 1, 1, 20'h0AAAA, 20'h00000, 0, 1, 0);
    step(1, 0, 0, 1, 20'h55555, 20'h00000, 0, 1, 0);
    step(1, 0, 0, 0, 20'h55555, 20'h55555, 1, 0, 0);
    step(1, 0, 0, 1, 20'h11111, 20'h55555, 1, 0, 0);
    step(1, 0, 0, 0, 20'h11111, 20'h11111, 1, 0, 0);
    step(1, 1, 0, 0, 20'h11111, 20'h00000, 0, 0, 0);

    // FLUSH_CYCLES = 3: full window, stalled window, reset aborting a window.
    step(3, 1, 0, 0, 20'h00000, 20'h00000, 0, 0, 0);
    step(3, 0, 0, 0, 20'h00F0F, 20'h00F0F, 1, 0, 0);
    step(3, 0, 1, 0, 20'h00F0F, 20'h00000, 0, 1, 2);
    step(3, 0, 0, 0, 20'h00F0F, 20'h00000, 0, 1, 1);
    step(3, 0, 0, 0, 20'h00F0F, 20'h00000, 0, 1, 0);
`ifdef CTRL_FLUSH_STATS_EN
    @(posedge clk); #2;
    check16("d3_flush_count", fc3, 16'd1);
    check16("d3_bubble_count", bc3, 16'd3);
`endif
    step(3, 0, 0, 0, 20'h00F0F, 20'h00F0F, 1, 0, 0);
    step(3, 0, 1, 0, 20'h0C0C0, 20'h00000, 0, 1, 2);
    step(3, 0, 0, 1, 20'h0C0C0, 20'h00000, 0, 1, 2);
    step(3, 0, 0, 1, 20'h0C0C0, 20'h00000, 0, 1, 2);
    step(3, 0, 0, 0, 20'h0C0C0, 20'h00000, 0, 1, 1);
    step(3, 0, 0, 0, 20'h0C0C0, 20'h00000, 0, 1, 0);
    step(3, 0, 0, 0, 20'h0C0C0, 20'h0C0C0, 1, 0, 0);
    step(3, 0, 1, 0, 20'h0C0C0, 20'h00000, 0, 1, 2);
    step(3, 1, 0, 0, 20'h0C0C0, 20'h00000, 0, 0, 0);
    step(3, 0, 0, 0, 20'h33333, 20'h33333, 1, 0, 0);

    // FLUSH_CYCLES = 3, KEEP_MASK = 1: restart and bit-0 pass-through.
    step(4, 1, 0, 0, 20'hABCDF, 20'h00000, 0, 0, 0);
    step(4, 0, 1, 0, 20'hABCDF, 20'h00001, 0, 1, 2);
    step(4, 0, 1, 0, 20'hABCDF, 20'h00001, 0, 1, 2);
    step(4, 0, 0, 0, 20'hABCDF, 20'h00001, 0, 1, 1);
    step(4, 0, 0, 0, 20'hABCDF, 20'h00001, 0, 1, 0);
    step(4, 0, 0, 0, 20'hABCDF, 20'hABCDF, 1, 0, 0);
    step(4, 0, 1, 0, 20'hABCDE, 20'h00000, 0, 1, 2);
    step(4, 0, 0, 0, 20'hABCDF, 20'h00001, 0, 1, 1);
    step(4, 0, 0, 0, 20'hABCDF, 20'h00001, 0, 1, 0);
    step(4, 0, 0, 0, 20'hABCDF, 20'hABCDF, 1, 0, 0);

    repeat (3) @(posedge clk);
    #2;
    n_cmp++;
    if ((q1.size() + q3.size() + qk.size()) != 0) begin
      n_err++;
      $display("FAIL drain: got %0d pending want 0", q1.size() + q3.size() + qk.size());
    end

`ifdef CTRL_FLUSH_STATS_EN
    // Saturation: hold S on the FLUSH_CYCLES=1 instance for 70000 edges.
    @(negedge clk);
    r1 = 1'b0; b1.S = 1'b1; b1.stall = 1'b0;
    repeat (70000) @(negedge clk);
    check16("d1_flush_sat", fc1, 16'hFFFF);
    check16("d1_bubble_sat", bc1, 16'hFFFF);
    b1.S = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
